// File: rtl/pol_max_acc_pkg.sv
// Shared pooling constants: core count, activations per word, activation
// and neighbour-count widths, plus the port-tag width helper. The crossbar
// and pool controller are built from the same constants.
package pol_max_acc_pkg;

  localparam int POOL_CORE_DEF      = 6;
  localparam int POOL_COMP_CORE_DEF = 64;
  localparam int ACT_WIDTH_DEF      = 8;
  localparam int NGH_WIDTH_DEF      = 8;

  // Width of the port tag. A single core still gets a 1-bit tag so the
  // {port, data} word never carries a zero-width field.
  function automatic int port_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pol_max_lane.sv
// One pool core: running element-wise max over K fetches, result held until popped.
// Latency: result valid the cycle after the K-th accepted word.
// Backpressure: pend stays high (and blocks this core's input upstream) until pop_rdy.
// Ports: clk/rst_n, clr (sync clear), acc_en (accept a word for this core),
//        data (one fetched word), k_num (fetches per point, already >= 1),
//        pop_rdy (consumer ready), pend (result valid), acc (running max / result).
module pol_max_lane
  import pol_max_acc_pkg::*;
#(
  parameter int LANES     = POOL_COMP_CORE_DEF,
  parameter int ACT_WIDTH = ACT_WIDTH_DEF,
  parameter int NGH_WIDTH = NGH_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         acc_en,
  input  logic [LANES*ACT_WIDTH-1:0]   data,
  input  logic [NGH_WIDTH-1:0]         k_num,
  input  logic                         pop_rdy,
  output logic                         pend,
  output logic [LANES*ACT_WIDTH-1:0]   acc
);

  logic [NGH_WIDTH-1:0]       cnt;
  logic [NGH_WIDTH-1:0]       cnt_inc;
  logic [LANES*ACT_WIDTH-1:0] max_vec;

  // Unsigned per-lane max; lanes never carry into each other.
  always_comb begin
    max_vec = '0;
    for (int l = 0; l < LANES; l++) begin
      max_vec[l*ACT_WIDTH +: ACT_WIDTH] =
        (acc[l*ACT_WIDTH +: ACT_WIDTH] > data[l*ACT_WIDTH +: ACT_WIDTH]) ?
        acc[l*ACT_WIDTH +: ACT_WIDTH] : data[l*ACT_WIDTH +: ACT_WIDTH];
    end
  end

  // Wraps modulo 2^NGH_WIDTH if k_num is changed mid-point.
  assign cnt_inc = cnt + NGH_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 1'b0;
      acc  <= '0;
    end else if (clr) begin
      cnt  <= '0;
      pend <= 1'b0;
      acc  <= '0;
    end else begin
      if (pend && pop_rdy) pend <= 1'b0;
      // acc_en is only raised while pend is low, so it never races the pop.
      if (acc_en) begin
        acc <= (cnt == '0) ? data : max_vec;
        if (cnt_inc == k_num) begin
          cnt  <= '0;
          pend <= 1'b1;
        end else begin
          cnt  <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: rtl/pol_max_acc.sv
// Pooling max stage: routes tagged fetch words to per-core max lanes, exposes per-core results.
// Latency: result valid one cycle after the K-th accept for that core; no bypass on pop.
// Backpressure: input ready drops while the tagged core holds an unpopped result; bad tags always accepted.
// Ports: clk, rst_n, CCUPOL_Rst (sync clear), CCUPOL_NghNum (K, 0 means 1),
//        MICPOL_Ofm/OfmVld/POLMIC_OfmRdy (tagged input), POLOUT_Vld/Ofm/OUTPOL_Rdy
//        (per-core results), POL_PortErr (sticky bad-tag flag).
module pol_max_acc
  import pol_max_acc_pkg::*;
#(
  parameter int POOL_CORE      = POOL_CORE_DEF,
  parameter int POOL_COMP_CORE = POOL_COMP_CORE_DEF,
  parameter int ACT_WIDTH      = ACT_WIDTH_DEF,
  parameter int NGH_WIDTH      = NGH_WIDTH_DEF,
  parameter int PORT_WIDTH     = port_width(POOL_CORE)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          CCUPOL_Rst,
  input  logic [NGH_WIDTH-1:0]                          CCUPOL_NghNum,
  input  logic [PORT_WIDTH+ACT_WIDTH*POOL_COMP_CORE-1:0] MICPOL_Ofm,
  input  logic                                          MICPOL_OfmVld,
  output logic                                          POLMIC_OfmRdy,
  output logic [POOL_CORE-1:0]                          POLOUT_Vld,
  output logic [ACT_WIDTH*POOL_COMP_CORE*POOL_CORE-1:0] POLOUT_Ofm,
  input  logic [POOL_CORE-1:0]                          OUTPOL_Rdy,
  output logic                                          POL_PortErr
);

  localparam int DW = ACT_WIDTH * POOL_COMP_CORE;

  logic [PORT_WIDTH-1:0] tag;
  logic [DW-1:0]         data;
  logic                  tag_ok;
  logic                  accept;
  logic [NGH_WIDTH-1:0]  k_num;
  logic [POOL_CORE-1:0]  pend;

  assign tag    = MICPOL_Ofm[DW +: PORT_WIDTH];
  assign data   = MICPOL_Ofm[DW-1:0];
  // Widen by one bit so the compare stays correct when POOL_CORE is a power of two.
  assign tag_ok = ({1'b0, tag} < (PORT_WIDTH+1)'(POOL_CORE));
  assign k_num  = (CCUPOL_NghNum == '0) ? NGH_WIDTH'(1) : CCUPOL_NghNum;

  // Out-of-range tags never match a core, so they see ready=1 and get dropped.
  always_comb begin
    POLMIC_OfmRdy = 1'b1;
    for (int i = 0; i < POOL_CORE; i++) begin
      if (tag == PORT_WIDTH'(i)) POLMIC_OfmRdy = !pend[i];
    end
  end

  assign accept     = MICPOL_OfmVld && POLMIC_OfmRdy;
  assign POLOUT_Vld = pend;

  for (genvar g = 0; g < POOL_CORE; g++) begin : g_lane
    pol_max_lane #(
      .LANES     (POOL_COMP_CORE),
      .ACT_WIDTH (ACT_WIDTH),
      .NGH_WIDTH (NGH_WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (CCUPOL_Rst),
      .acc_en  (accept && (tag == PORT_WIDTH'(g))),
      .data    (data),
      .k_num   (k_num),
      .pop_rdy (OUTPOL_Rdy[g]),
      .pend    (pend[g]),
      .acc     (POLOUT_Ofm[g*DW +: DW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      POL_PortErr <= 1'b0;
    end else if (CCUPOL_Rst) begin
      POL_PortErr <= 1'b0;
    end else if (accept && !tag_ok) begin
      POL_PortErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pol_max_acc.sv
module tb_pol_max_acc;
  import pol_max_acc_pkg::*;

  localparam int NC = POOL_CORE_DEF;
  localparam int LN = POOL_COMP_CORE_DEF;
  localparam int AW = ACT_WIDTH_DEF;
  localparam int NW = NGH_WIDTH_DEF;
  localparam int PW = port_width(POOL_CORE_DEF);
  localparam int DW = AW * LN;

  logic             clk;
  logic             rst_n;
  logic             CCUPOL_Rst;
  logic [NW-1:0]    CCUPOL_NghNum;
  logic [PW+DW-1:0] MICPOL_Ofm;
  logic             MICPOL_OfmVld;
  logic             POLMIC_OfmRdy;
  logic [NC-1:0]    POLOUT_Vld;
  logic [DW*NC-1:0] POLOUT_Ofm;
  logic [NC-1:0]    OUTPOL_Rdy;
  logic             POL_PortErr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: words collected per core for the current point.
  logic [DW-1:0] mq[NC][$];
  logic [NC-1:0] mpend;
  logic [DW-1:0] mres[NC];
  logic          merr;

  pol_max_acc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .CCUPOL_Rst    (CCUPOL_Rst),
    .CCUPOL_NghNum (CCUPOL_NghNum),
    .MICPOL_Ofm    (MICPOL_Ofm),
    .MICPOL_OfmVld (MICPOL_OfmVld),
    .POLMIC_OfmRdy (POLMIC_OfmRdy),
    .POLOUT_Vld    (POLOUT_Vld),
    .POLOUT_Ofm    (POLOUT_Ofm),
    .OUTPOL_Rdy    (OUTPOL_Rdy),
    .POL_PortErr   (POL_PortErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [DW-1:0] fill(input logic [AW-1:0] v);
    return {LN{v}};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      mres[i] = '0;
    end
    mpend = '0;
    merr  = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs seen at that edge.
  task automatic tick();
    int k;
    int tg;
    logic [DW-1:0] dat;
    logic [DW-1:0] res;
    logic [DW-1:0] w;
    logic mrdy;
    k    = (CCUPOL_NghNum == 0) ? 1 : int'(CCUPOL_NghNum);
    tg   = int'(MICPOL_Ofm[DW +: PW]);
    dat  = MICPOL_Ofm[DW-1:0];
    mrdy = (tg < NC) ? !mpend[tg] : 1'b1;
    if (CCUPOL_Rst) begin
      model_clear();
    end else begin
      for (int i = 0; i < NC; i++)
        if (mpend[i] && OUTPOL_Rdy[i]) mpend[i] = 1'b0;
      if (MICPOL_OfmVld && mrdy) begin
        if (tg < NC) begin
          mq[tg].push_back(dat);
          if (mq[tg].size() == k) begin
            res = '0;
            for (int j = 0; j < mq[tg].size(); j++) begin
              w = mq[tg][j];
              for (int l = 0; l < LN; l++)
                if (w[l*AW +: AW] > res[l*AW +: AW]) res[l*AW +: AW] = w[l*AW +: AW];
            end
            mres[tg]  = res;
            mpend[tg] = 1'b1;
            mq[tg].delete();
          end
        end else begin
          merr = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sync_clear();
    MICPOL_OfmVld = 1'b0;
    OUTPOL_Rdy    = '0;
    CCUPOL_Rst    = 1'b1;
    tick();
    CCUPOL_Rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; CCUPOL_Rst = 1'b0; CCUPOL_NghNum = '0;
    MICPOL_Ofm = '0; MICPOL_OfmVld = 1'b0; OUTPOL_Rdy = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (POLOUT_Vld !== '0) begin n_fail++; $display("FAIL reset_vld got=%h exp=0", POLOUT_Vld); end
    n_tests++; if (POLOUT_Ofm !== '0) begin n_fail++; $display("FAIL reset_ofm got nonzero exp=0"); end
    n_tests++; if (POL_PortErr !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", POL_PortErr); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (POLMIC_OfmRdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got=%b exp=1", POLMIC_OfmRdy); end
  endtask

  task automatic test_k3_max();
    sync_clear();
    CCUPOL_NghNum = 8'd3;
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(2), fill(8'd5)}; tick();
    MICPOL_Ofm = {PW'(2), fill(8'd9)}; tick();
    n_tests++; if (POLOUT_Vld !== '0) begin n_fail++; $display("FAIL k3_early_vld got=%b exp=0", POLOUT_Vld); end
    MICPOL_Ofm = {PW'(2), fill(8'd7)}; tick();
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POLOUT_Vld !== 6'b000100) begin n_fail++; $display("FAIL k3_vld got=%b exp=000100", POLOUT_Vld); end
    n_tests++; if (POLOUT_Ofm[2*DW +: DW] !== fill(8'd9)) begin n_fail++; $display("FAIL k3_data got=%h exp=all 09", POLOUT_Ofm[2*DW +: DW]); end
    OUTPOL_Rdy = '1; tick(); OUTPOL_Rdy = '0;
    n_tests++; if (POLOUT_Vld !== '0) begin n_fail++; $display("FAIL k3_pop got=%b exp=0", POLOUT_Vld); end
  endtask

  task automatic test_unsigned();
    logic [DW-1:0] w1, w2, ex;
    sync_clear();
    CCUPOL_NghNum = 8'd2;
    w1 = '0; w1[7:0] = 8'd200; w1[15:8] = 8'd3;
    w2 = '0; w2[7:0] = 8'd10;  w2[15:8] = 8'd250;
    ex = '0; ex[7:0] = 8'd200; ex[15:8] = 8'd250;
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(0), w1}; tick();
    MICPOL_Ofm = {PW'(0), w2}; tick();
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POLOUT_Vld !== 6'b000001) begin n_fail++; $display("FAIL uns_vld got=%b exp=000001", POLOUT_Vld); end
    n_tests++; if (POLOUT_Ofm[DW-1:0] !== ex) begin n_fail++; $display("FAIL uns_data got=%h exp=%h", POLOUT_Ofm[15:0], ex[15:0]); end
  endtask

  task automatic test_stall_bubble();
    sync_clear();
    CCUPOL_NghNum = 8'd1;
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(1), fill(8'd33)}; tick();
    MICPOL_Ofm = {PW'(1), fill(8'd44)}; #1;
    n_tests++; if (POLMIC_OfmRdy !== 1'b0) begin n_fail++; $display("FAIL stall_rdy got=%b exp=0", POLMIC_OfmRdy); end
    tick();
    n_tests++; if (POLOUT_Ofm[DW +: DW] !== fill(8'd33)) begin n_fail++; $display("FAIL stall_hold got=%h exp=all 21", POLOUT_Ofm[DW +: 16]); end
    OUTPOL_Rdy = 6'b000010; #1;
    n_tests++; if (POLMIC_OfmRdy !== 1'b0) begin n_fail++; $display("FAIL bubble_rdy got=%b exp=0", POLMIC_OfmRdy); end
    tick();
    OUTPOL_Rdy = '0; #1;
    n_tests++; if (POLOUT_Vld[1] !== 1'b0) begin n_fail++; $display("FAIL bubble_pop got=%b exp=0", POLOUT_Vld[1]); end
    n_tests++; if (POLMIC_OfmRdy !== 1'b1) begin n_fail++; $display("FAIL after_pop_rdy got=%b exp=1", POLMIC_OfmRdy); end
    tick();
    n_tests++; if (POLOUT_Ofm[DW +: DW] !== fill(8'd44)) begin n_fail++; $display("FAIL stall_second got=%h exp=all 2c", POLOUT_Ofm[DW +: 16]); end
    MICPOL_Ofm = {PW'(4), fill(8'd55)}; #1;
    n_tests++; if (POLMIC_OfmRdy !== 1'b1) begin n_fail++; $display("FAIL port4_rdy got=%b exp=1", POLMIC_OfmRdy); end
    tick();
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POLOUT_Vld !== 6'b010010) begin n_fail++; $display("FAIL port4_vld got=%b exp=010010", POLOUT_Vld); end
  endtask

  task automatic test_interleave();
    sync_clear();
    CCUPOL_NghNum = 8'd2;
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(0), fill(8'd40)}; tick();
    MICPOL_Ofm = {PW'(3), fill(8'd90)}; tick();
    MICPOL_Ofm = {PW'(0), fill(8'd60)}; tick();
    n_tests++; if (POLOUT_Vld !== 6'b000001) begin n_fail++; $display("FAIL il_vld3 got=%b exp=000001", POLOUT_Vld); end
    MICPOL_Ofm = {PW'(3), fill(8'd30)}; tick();
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POLOUT_Vld !== 6'b001001) begin n_fail++; $display("FAIL il_vld4 got=%b exp=001001", POLOUT_Vld); end
    n_tests++; if (POLOUT_Ofm[0 +: DW] !== fill(8'd60)) begin n_fail++; $display("FAIL il_p0 got=%h exp=all 3c", POLOUT_Ofm[0 +: 16]); end
    n_tests++; if (POLOUT_Ofm[3*DW +: DW] !== fill(8'd90)) begin n_fail++; $display("FAIL il_p3 got=%h exp=all 5a", POLOUT_Ofm[3*DW +: 16]); end
    OUTPOL_Rdy = 6'b001001; tick(); OUTPOL_Rdy = '0;
    n_tests++; if (POLOUT_Vld !== '0) begin n_fail++; $display("FAIL il_pop got=%b exp=0", POLOUT_Vld); end
    // Counts must be back at zero: a fresh pair overwrites the old max.
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(0), fill(8'd1)}; tick();
    MICPOL_Ofm = {PW'(0), fill(8'd2)}; tick();
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POLOUT_Ofm[0 +: DW] !== fill(8'd2)) begin n_fail++; $display("FAIL il_fresh got=%h exp=all 02", POLOUT_Ofm[0 +: 16]); end
  endtask

  task automatic test_port_err();
    sync_clear();
    CCUPOL_NghNum = 8'd1;
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(7), fill(8'd77)}; #1;
    n_tests++; if (POLMIC_OfmRdy !== 1'b1) begin n_fail++; $display("FAIL err_rdy got=%b exp=1", POLMIC_OfmRdy); end
    tick();
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POL_PortErr !== 1'b1) begin n_fail++; $display("FAIL err_set got=%b exp=1", POL_PortErr); end
    n_tests++; if (POLOUT_Vld !== '0) begin n_fail++; $display("FAIL err_vld got=%b exp=0", POLOUT_Vld); end
    tick(); tick();
    n_tests++; if (POL_PortErr !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", POL_PortErr); end
  endtask

  task automatic test_sync_rst();
    sync_clear();
    CCUPOL_NghNum = 8'd2;
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(5), fill(8'd200)}; tick();
    MICPOL_Ofm = {PW'(2), fill(8'd1)}; tick();
    MICPOL_Ofm = {PW'(2), fill(8'd2)}; tick();
    MICPOL_Ofm = {PW'(6), fill(8'd0)}; tick();
    // Clear wins over the same-cycle handshake on port 5.
    MICPOL_Ofm = {PW'(5), fill(8'd250)};
    CCUPOL_Rst = 1'b1; tick(); CCUPOL_Rst = 1'b0;
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POLOUT_Vld !== '0) begin n_fail++; $display("FAIL srst_vld got=%b exp=0", POLOUT_Vld); end
    n_tests++; if (POL_PortErr !== 1'b0) begin n_fail++; $display("FAIL srst_err got=%b exp=0", POL_PortErr); end
    n_tests++; if (POLOUT_Ofm !== '0) begin n_fail++; $display("FAIL srst_ofm got nonzero exp=0"); end
    MICPOL_OfmVld = 1'b1;
    MICPOL_Ofm = {PW'(5), fill(8'd10)}; tick();
    MICPOL_Ofm = {PW'(5), fill(8'd20)}; tick();
    MICPOL_OfmVld = 1'b0;
    n_tests++; if (POLOUT_Vld !== 6'b100000) begin n_fail++; $display("FAIL srst_new_vld got=%b exp=100000", POLOUT_Vld); end
    n_tests++; if (POLOUT_Ofm[5*DW +: DW] !== fill(8'd20)) begin n_fail++; $display("FAIL srst_new got=%h exp=all 14", POLOUT_Ofm[5*DW +: 16]); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic exp_rdy;
    int tg;
    for (int seg = 0; seg < 5; seg++) begin
      sync_clear();
      CCUPOL_NghNum = NW'($urandom_range(0, 4));
      for (int c = 0; c < 200; c++) begin
        tg = ($urandom_range(0, 19) == 0) ? 6 + $urandom_range(0, 1) : $urandom_range(0, NC-1);
        for (int b = 0; b < DW/32; b++) d[b*32 +: 32] = $urandom;
        MICPOL_Ofm    = {PW'(tg), d};
        MICPOL_OfmVld = ($urandom_range(0, 3) != 0);
        OUTPOL_Rdy    = NC'($urandom);
        #1;
        exp_rdy = (tg < NC) ? !mpend[tg] : 1'b1;
        n_tests++; if (POLMIC_OfmRdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_rdy seg=%0d cyc=%0d got=%b exp=%b", seg, c, POLMIC_OfmRdy, exp_rdy); end
        n_tests++; if (POLOUT_Vld !== mpend) begin n_fail++; $display("FAIL rnd_vld seg=%0d cyc=%0d got=%b exp=%b", seg, c, POLOUT_Vld, mpend); end
        n_tests++; if (POL_PortErr !== merr) begin n_fail++; $display("FAIL rnd_err seg=%0d cyc=%0d got=%b exp=%b", seg, c, POL_PortErr, merr); end
        for (int i = 0; i < NC; i++) begin
          if (mpend[i]) begin
            n_tests++;
            if (POLOUT_Ofm[i*DW +: DW] !== mres[i]) begin
              n_fail++;
              $display("FAIL rnd_data seg=%0d cyc=%0d core=%0d got=%h exp=%h", seg, c, i, POLOUT_Ofm[i*DW +: 64], mres[i][63:0]);
            end
          end
        end
        tick();
      end
    end
    MICPOL_OfmVld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_k3_max();
    test_unsigned();
    test_stall_bubble();
    test_interleave();
    test_port_err();
    test_sync_rst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pol_max_acc.md
Name: pol_max_acc

Overview:
- Pooling reduction stage directly downstream of the pooling memory-interface crossbar.
- Consumes the tagged fetch stream {port id, POOL_COMP_CORE activations} and keeps one running element-wise max per pool core.
- After NGH_NUM fetches for a core, presents that core's pooled vector on a per-core valid/ready output, then clears the core for its next point.

Parameters:
- POOL_CORE, 6, number of pool cores (ports).
- POOL_COMP_CORE, 64, activations per fetched word.
- ACT_WIDTH, 8, bits per activation, unsigned (post-ReLU).
- NGH_WIDTH, 8, width of the neighbour-count configuration.
- PORT_WIDTH, $clog2(POOL_CORE), width of the port tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- CCUPOL_Rst  in  1  synchronous clear, same effect as reset.
- CCUPOL_NghNum  in  NGH_WIDTH  fetches per pooled point. Held stable while any core is mid-point. A value of 0 is treated as 1.
- MICPOL_Ofm  in  PORT_WIDTH+ACT_WIDTH*POOL_COMP_CORE  {port, data}; the port tag is in the MSBs.
- MICPOL_OfmVld  in  1  input valid.
- POLMIC_OfmRdy  out  1  input ready.
- POLOUT_Vld  out  POOL_CORE  per-core result valid.
- POLOUT_Ofm  out  ACT_WIDTH*POOL_COMP_CORE*POOL_CORE  per-core pooled vector; core i occupies slice i.
- OUTPOL_Rdy  in  POOL_CORE  per-core result ready.
- POL_PortErr  out  1  sticky flag: a tag ≥ POOL_CORE was received.

Behaviour:
- Reset (rst_n low, asynchronous) or CCUPOL_Rst (synchronous) clears every cnt[i], pend[i], acc[i] and POL_PortErr to 0.
  - Outputs after reset: POLOUT_Vld=0, POLOUT_Ofm=0, POL_PortErr=0.
  - CCUPOL_Rst takes priority over any same-cycle handshake; the handshake is lost.
- Per-core state:
  - cnt[i], NGH_WIDTH bits, fetches accumulated so far.
  - pend[i], result waiting for its consumer.
  - acc[i], running max vector.
- Input ready: POLMIC_OfmRdy = !pend[p] when tag p < POOL_CORE, and 1 when the tag is out of range. It is combinational on the tag field.
- Accept occurs when MICPOL_OfmVld & POLMIC_OfmRdy. On accept for p < POOL_CORE:
  - If cnt[p]==0, acc[p] <= data (overwrite).
  - Otherwise acc[p] <= element-wise unsigned max(acc[p], data), per ACT_WIDTH lane, with no widening.
  - If cnt[p]+1 == K (K = max(CCUPOL_NghNum,1)), then cnt[p] <= 0 and pend[p] <= 1. Otherwise cnt[p] <= cnt[p]+1.
- Out-of-range tag: the word is accepted and dropped, and POL_PortErr is set to 1. It is cleared only by a reset.
- Output side:
  - POLOUT_Vld[i] = pend[i].
  - POLOUT_Ofm slice i = acc[i], held stable while pend[i]=1.
  - On POLOUT_Vld[i] & OUTPOL_Rdy[i], pend[i] <= 0.
- Latency: the result for a point is valid in the cycle after the K-th accept. With K=1 every accepted word appears as a result one cycle later.
- No bypass: while pend[p]=1, input tagged p stalls, including the cycle in which pend[p] is being popped. This gives a one-cycle bubble per point per core.
  - Other cores' tags continue to be accepted; per-core state is independent.
  - The input is a single in-order stream, so a stalled head word blocks all later words. This is intended; the upstream FIFO absorbs the stall.
- Only one input accept per cycle. Pops on several cores in the same cycle are allowed.
- Mid-point reconfiguration of CCUPOL_NghNum is illegal. If it happens, the completion compare uses the current value, and the count wraps modulo 2^NGH_WIDTH.
- The result for each core is the elementwise max over exactly K words; the order in which words arrive does not affect the result.

Decomposition:
- Shared pool package holds POOL_CORE, POOL_COMP_CORE, ACT_WIDTH and NGH_WIDTH defaults, plus the PORT_WIDTH function. These are the same constants the crossbar and pool controller use.
- One natural sub-module, pol_max_lane: one core's cnt/pend/acc registers and the vector max, instantiated POOL_CORE times by generate.
- The top level holds the tag decode, the ready mux and the error flag.

Test Plan:
- K=3, port 2 receives lanes all 5, then 9, then 7 → POLOUT_Vld[2]=1 one cycle after the third accept, with every lane=9. Other Vld bits stay 0.
- K=2, port 0 receives lane0={200,10}, lane1={3,250} → lane0=200, lane1=250. This checks the unsigned compare (200 > 10 must not be treated as negative).
- Port 1 result pending with OUTPOL_Rdy[1]=0, next inputs tagged 1 then 4:
  - POLMIC_OfmRdy=0 and the tag-1 word is held.
  - Raise OUTPOL_Rdy[1] → pop, then accept on the following cycle (one bubble).
  - Afterwards the port-4 word is accepted.
- Interleaved ports 0,3,0,3 with K=2 → two independent results, maxima correct per port, cnt for both back at 0.
- Tag 7 with POOL_CORE=6 → word accepted (Rdy=1), no state change, POL_PortErr=1 until reset.
- Assert CCUPOL_Rst with port 5 at cnt=1 and port 2 pending → next cycle all Vld=0. A fresh K-word sequence on port 5 then gives a max computed from the new words only.
